// File: rtl/morse_key_decoder.sv
// morse_key_decoder: debounced Morse key to ASCII letter decoder
// Ports: clk, rst (async, active-low), tick (timebase enable), key (raw, async)
//        ASCIIOutput (last decoded char), LetterEnter (1-cycle pulse),
//        symbol_count (elements in current letter), key_down (debounced key)
// Optional macro MORSE_DIGITS_EN adds the 5-element digit codes 0-9.
module morse_key_decoder #(
    parameter int DEBOUNCE_TICKS   = 5,
    parameter int DOT_MAX_TICKS    = 250,
    parameter int LETTER_GAP_TICKS = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key,
    output logic [7:0] ASCIIOutput,
    output logic       LetterEnter,
    output logic [2:0] symbol_count,
    output logic       key_down
);
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_TICKS - 1);
    localparam logic [15:0] DOT_MAX = 16'(DOT_MAX_TICKS);
    localparam logic [15:0] GAP_END = 16'(LETTER_GAP_TICKS);
    state_t      state_q;
    logic        sync1_q, sync2_q, kd_q, kd_prev_q;
    logic [15:0] db_cnt_q, press_cnt_q, gap_cnt_q;
    logic [4:0]  pattern_q;
    logic [2:0]  count_q;
    logic        ovf_q, le_q;
    logic [7:0]  ascii_q, lut;
    logic        rise, fall, element;
    assign rise         = kd_q & ~kd_prev_q;
    assign fall         = ~kd_q & kd_prev_q;
    assign element      = press_cnt_q >= DOT_MAX;
    assign ASCIIOutput  = ascii_q;
    assign LetterEnter  = le_q;
    assign symbol_count = count_q;
    assign key_down     = kd_q;
    // Debounce counter restarts whenever the synchronized level matches key_down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            kd_q      <= 1'b0;
            kd_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= key;
            sync2_q   <= sync1_q;
            kd_prev_q <= kd_q;
            if (sync2_q == kd_q) begin
                db_cnt_q <= '0;
            end else if (tick) begin
                db_cnt_q <= (db_cnt_q == DB_LAST) ? '0 : db_cnt_q + 16'd1;
                if (db_cnt_q == DB_LAST) kd_q <= sync2_q;
            end
        end
    end
    // Code sits right-aligned in pattern, first element in the highest used bit.
    always_comb begin
        lut = 8'h3F;
        if (!ovf_q) begin
            case ({count_q, pattern_q})
                {3'd2, 5'b00001}: lut = 8'h41;
                {3'd4, 5'b01000}: lut = 8'h42;
                {3'd4, 5'b01010}: lut = 8'h43;
                {3'd3, 5'b00100}: lut = 8'h44;
                {3'd1, 5'b00000}: lut = 8'h45;
                {3'd4, 5'b00010}: lut = 8'h46;
                {3'd3, 5'b00110}: lut = 8'h47;
                {3'd4, 5'b00000}: lut = 8'h48;
                {3'd2, 5'b00000}: lut = 8'h49;
                {3'd4, 5'b00111}: lut = 8'h4A;
                {3'd3, 5'b00101}: lut = 8'h4B;
                {3'd4, 5'b00100}: lut = 8'h4C;
                {3'd2, 5'b00011}: lut = 8'h4D;
                {3'd2, 5'b00010}: lut = 8'h4E;
                {3'd3, 5'b00111}: lut = 8'h4F;
                {3'd4, 5'b00110}: lut = 8'h50;
                {3'd4, 5'b01101}: lut = 8'h51;
                {3'd3, 5'b00010}: lut = 8'h52;
                {3'd3, 5'b00000}: lut = 8'h53;
                {3'd1, 5'b00001}: lut = 8'h54;
                {3'd3, 5'b00001}: lut = 8'h55;
                {3'd4, 5'b00001}: lut = 8'h56;
                {3'd3, 5'b00011}: lut = 8'h57;
                {3'd4, 5'b01001}: lut = 8'h58;
                {3'd4, 5'b01011}: lut = 8'h59;
                {3'd4, 5'b01100}: lut = 8'h5A;
`ifdef MORSE_DIGITS_EN
                {3'd5, 5'b11111}: lut = 8'h30;
                {3'd5, 5'b01111}: lut = 8'h31;
                {3'd5, 5'b00111}: lut = 8'h32;
                {3'd5, 5'b00011}: lut = 8'h33;
                {3'd5, 5'b00001}: lut = 8'h34;
                {3'd5, 5'b00000}: lut = 8'h35;
                {3'd5, 5'b10000}: lut = 8'h36;
                {3'd5, 5'b11000}: lut = 8'h37;
                {3'd5, 5'b11100}: lut = 8'h38;
                {3'd5, 5'b11110}: lut = 8'h39;
`endif
                default:          lut = 8'h3F;
            endcase
        end
    end
    // Key edges take priority over a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            pattern_q   <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            ascii_q     <= '0;
            le_q        <= 1'b0;
        end else begin
            le_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        press_cnt_q <= '0;
                        state_q     <= PRESS;
                    end
                end
                PRESS: begin
                    if (fall) begin
                        if (count_q == 3'd5) begin
                            ovf_q <= 1'b1;
                        end else begin
                            pattern_q <= {pattern_q[3:0], element};
                            count_q   <= count_q + 3'd1;
                        end
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else if (tick && press_cnt_q != 16'hFFFF) begin
                        press_cnt_q <= press_cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q >= GAP_END) begin
                        ascii_q   <= lut;
                        le_q      <= 1'b1;
                        pattern_q <= '0;
                        count_q   <= '0;
                        ovf_q     <= 1'b0;
                        state_q   <= IDLE;
                    end else if (rise) begin
                        press_cnt_q <= '0;
                        state_q     <= PRESS;
                    end else if (tick) begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: self-checking bench for morse_key_decoder
module tb_morse_key_decoder;
    typedef struct {
        logic [4:0] code;
        int         n;
        logic [7:0] exp;
    } vec_t;
`ifdef MORSE_DIGITS_EN
    localparam logic [7:0] DIG0 = 8'h30;
    localparam logic [7:0] DIG5 = 8'h35;
`else
    localparam logic [7:0] DIG0 = 8'h3F;
    localparam logic [7:0] DIG5 = 8'h3F;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key = 1'b0;
    logic       tick;
    logic [1:0] tc = 2'd0;
    logic [7:0] ASCIIOutput;
    logic       LetterEnter;
    logic [2:0] symbol_count;
    logic       key_down;
    int         le_count = 0;
    logic [7:0] last_ascii = 8'h00;
    logic       le_prev = 1'b0;
    logic       consec = 1'b0;
    int         tests = 0;
    int         fails = 0;
    int         seen = 0;
    logic [7:0] exp_q[$];
    always #5 clk = ~clk;
    always @(posedge clk) tc <= (tc == 2'd2) ? 2'd0 : tc + 2'd1;
    assign tick = (tc == 2'd2);
    morse_key_decoder dut (
        .clk(clk), .rst(rst), .tick(tick), .key(key),
        .ASCIIOutput(ASCIIOutput), .LetterEnter(LetterEnter),
        .symbol_count(symbol_count), .key_down(key_down)
    );
    always @(negedge clk) begin
        if (LetterEnter) begin
            le_count   <= le_count + 1;
            last_ascii <= ASCIIOutput;
        end
        if (LetterEnter && le_prev) consec <= 1'b1;
        le_prev <= LetterEnter;
    end
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(negedge clk); while (tc != 2'd0);
        end
    endtask
    task automatic press(input int len, input int gap);
        key = 1'b1;
        ticks(len);
        key = 1'b0;
        ticks(gap);
    endtask
    task automatic wait_letter(input string nm);
        int g;
        logic [7:0] e;
        g = 0;
        e = 8'hxx;
        while (le_count == seen && g < 700) begin
            ticks(1);
            g++;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        ticks(5);
        check({nm, " pulses"}, le_count, seen + 1);
        check({nm, " ascii@pulse"}, last_ascii, e);
        check({nm, " ascii held"}, ASCIIOutput, e);
        check({nm, " symbol_count"}, symbol_count, 0);
        seen = le_count;
    endtask
    task automatic send(input logic [4:0] code, input int n, input logic [7:0] exp);
        exp_q.push_back(exp);
        for (int i = n - 1; i >= 0; i--) press(code[i] ? 260 : 50, (i > 0) ? 50 : 0);
        wait_letter($sformatf("table %0h", exp));
    endtask
    initial begin
        #950000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end
    initial begin
        vec_t vecs[4];
        vecs[0] = '{5'b00101, 3, 8'h4B};
        vecs[1] = '{5'b01101, 4, 8'h51};
        vecs[2] = '{5'b00011, 3, 8'h57};
        vecs[3] = '{5'b00000, 5, DIG5};
        repeat (3) @(negedge clk);
        check("reset ascii", ASCIIOutput, 0);
        check("reset le", LetterEnter, 0);
        check("reset count", symbol_count, 0);
        check("reset key_down", key_down, 0);
        rst = 1'b1;
        ticks(2);
        for (int b = 1; b <= 3; b++) begin
            key = 1'b1;
            ticks(b);
            check($sformatf("bounce%0d key_down", b), key_down, 0);
            key = 1'b0;
            ticks(10);
            check($sformatf("bounce%0d count", b), symbol_count, 0);
            check($sformatf("bounce%0d pulses", b), le_count, seen);
        end
        exp_q.push_back(8'h41);
        press(100, 100);
        press(400, 0);
        wait_letter("A");
        for (int i = 0; i < 4; i++) send(vecs[i].code, vecs[i].n, vecs[i].exp);
        exp_q.push_back(8'h45);
        press(249, 0);
        wait_letter("dot249");
        exp_q.push_back(8'h54);
        press(250, 0);
        wait_letter("dash250");
        exp_q.push_back(8'h3F);
        for (int i = 0; i < 3; i++) press(249, 100);
        for (int i = 0; i < 3; i++) press(250, (i < 2) ? 100 : 10);
        check("overflow count held", symbol_count, 5);
        wait_letter("overflow");
        exp_q.push_back(DIG0);
        for (int i = 0; i < 5; i++) press(400, (i < 4) ? 100 : 0);
        wait_letter("digit0");
        press(100, 100);
        press(100, 200);
        rst = 1'b0;
        ticks(1);
        check("midgap rst ascii", ASCIIOutput, 0);
        check("midgap rst le", LetterEnter, 0);
        check("midgap rst count", symbol_count, 0);
        check("midgap rst key_down", key_down, 0);
        rst = 1'b1;
        ticks(700);
        check("midgap rst no letter", le_count, seen);
        exp_q.push_back(8'h49);
        press(100, 599);
        key = 1'b1;
        ticks(20);
        check("gap599 no letter", le_count, seen);
        ticks(80);
        key = 1'b0;
        ticks(10);
        check("gap599 continues", symbol_count, 2);
        wait_letter("I");
        rst = 1'b0;
        key = 1'b1;
        ticks(1);
        check("held key in rst", key_down, 0);
        rst = 1'b1;
        ticks(4);
        check("held key 4 ticks", key_down, 0);
        ticks(2);
        check("held key 6 ticks", key_down, 1);
        exp_q.push_back(8'h45);
        key = 1'b0;
        wait_letter("post-reset E");
        check("no back-to-back pulse", consec, 0);
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
